// File: rtl/cpu_pkg.sv
// Shared types and constants for the memory address sequencer.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } seq_state_e;

   localparam int unsigned VEC_BASE_DEF = 253;

   // Out-of-range exception codes fall onto the last vector slot.
   function automatic int unsigned vec_slot(input logic [1:0] code, input int unsigned num_vec);
      int unsigned c;
      c = {30'd0, code};
      return (c > num_vec - 1) ? num_vec - 1 : c;
   endfunction

endpackage

// File: rtl/src_mux.sv
// Combinational NUM_SRC-to-1 selector over a packed bus of DATA_W-bit sources.
module src_mux #(
   parameter  int DATA_W  = 32,
   parameter  int NUM_SRC = 2,
   localparam int SEL_W   = $clog2(NUM_SRC)
) (
   input  logic [SEL_W-1:0]          sel,
   input  logic [NUM_SRC*DATA_W-1:0] din,
   output logic [DATA_W-1:0]         dout
);

   // Unused select codes (non power-of-two NUM_SRC) return zero.
   always_comb begin
      dout = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (sel == SEL_W'(i)) dout = din[i*DATA_W +: DATA_W];
      end
   end

endmodule

// File: rtl/mem_addr_seq.sv
// Memory address sequencer: general address loads plus exception vector fetch.
// Define MEM_ADDR_SEQ_PEND_EN to queue one exception request arriving mid-fetch.
module mem_addr_seq
   import cpu_pkg::*;
#(
   parameter  int          DATA_W   = 32,
   parameter  int          NUM_SRC  = 2,
   parameter  int unsigned VEC_BASE = VEC_BASE_DEF,
   parameter  int unsigned NUM_VEC  = 3,
   parameter  int          MEM_LAT  = 1,
   localparam int          SEL_W    = $clog2(NUM_SRC)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [SEL_W-1:0]          sel_src,
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   input  logic                      addr_ld,
   input  logic                      exc_req,
   input  logic [1:0]                exc_code,
   input  logic [7:0]                mem_rdata,
   output logic [DATA_W-1:0]         addr_out,
   output logic                      busy,
   output logic [DATA_W-1:0]         vec_addr,
   output logic                      vec_valid
);

   localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

   seq_state_e        state_q, state_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] vec_q, vec_d;
   logic              busy_q, busy_d;
   logic              valid_q, valid_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] mux_out;
   logic              start;
   logic [1:0]        start_code;

`ifdef MEM_ADDR_SEQ_PEND_EN
   logic              pend_q, pend_d;
   logic [1:0]        pend_code_q, pend_code_d;
`endif

   src_mux #(
      .DATA_W  (DATA_W),
      .NUM_SRC (NUM_SRC)
   ) u_src_mux (
      .sel  (sel_src),
      .din  (src_data),
      .dout (mux_out)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      vec_d      = vec_q;
      busy_d     = busy_q;
      valid_d    = 1'b0;
      cnt_d      = cnt_q;
      start      = 1'b0;
      start_code = exc_code;
`ifdef MEM_ADDR_SEQ_PEND_EN
      pend_d      = pend_q;
      pend_code_d = pend_code_q;
`endif

      case (state_q)
         IDLE: begin
`ifdef MEM_ADDR_SEQ_PEND_EN
            // A queued request goes first; a fresh one in the same cycle takes its place in the queue.
            if (pend_q) begin
               start       = 1'b1;
               start_code  = pend_code_q;
               pend_d      = exc_req;
               pend_code_d = exc_code;
            end else if (exc_req) begin
               start = 1'b1;
            end
`else
            start = exc_req;
`endif
            if (start) begin
               addr_d  = DATA_W'(VEC_BASE + vec_slot(start_code, NUM_VEC));
               busy_d  = 1'b1;
               cnt_d   = '0;
               state_d = WAIT;
            end else if (addr_ld) begin
               addr_d = mux_out;
            end
         end
         WAIT: begin
            if (cnt_q == LAT_LAST) begin
               vec_d   = DATA_W'(mem_rdata);
               valid_d = 1'b1;
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

`ifdef MEM_ADDR_SEQ_PEND_EN
      if (state_q != IDLE && exc_req && !pend_q) begin
         pend_d      = 1'b1;
         pend_code_d = exc_code;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         vec_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
`ifdef MEM_ADDR_SEQ_PEND_EN
         pend_q      <= 1'b0;
         pend_code_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         vec_q   <= vec_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
`ifdef MEM_ADDR_SEQ_PEND_EN
         pend_q      <= pend_d;
         pend_code_q <= pend_code_d;
`endif
      end
   end

   assign addr_out  = addr_q;
   assign busy      = busy_q;
   assign vec_addr  = vec_q;
   assign vec_valid = valid_q;

endmodule

// File: doc/mem_addr_seq.md
MEM_ADDR_SEQ -- requirements
Module: mem_addr_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of address sources and addr_out.
REQ-002 SHALL have parameter NUM_SRC, default 2: number of general address sources (>=2).
REQ-003 SHALL have parameter VEC_BASE, default 253: byte address of the first exception vector slot.
REQ-004 SHALL have parameter NUM_VEC, default 3: number of vector slots.
REQ-005 SHALL have parameter MEM_LAT, default 1: memory read latency in cycles (1..7).
REQ-006 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high.
REQ-008 SHALL have port sel_src, input, $clog2(NUM_SRC): general source select.
REQ-009 SHALL have port src_data, input, NUM_SRC*DATA_W: packed sources, source i at bits [i*DATA_W +: DATA_W].
REQ-010 SHALL have port addr_ld, input, 1: load the selected source into addr_out.
REQ-011 SHALL have port exc_req, input, 1: single-cycle exception request.
REQ-012 SHALL have port exc_code, input, 2: vector slot index.
REQ-013 SHALL have port mem_rdata, input, 8: memory byte read data.
REQ-014 SHALL have port addr_out, output, DATA_W: registered memory address.
REQ-015 SHALL have port busy, output, 1: vector fetch in progress.
REQ-016 SHALL have port vec_addr, output, DATA_W: captured handler address, zero-extended byte.
REQ-017 SHALL have port vec_valid, output, 1: one-cycle pulse when vec_addr updates.

Function
REQ-018 SHALL implement an FSM with states IDLE, WAIT and DONE.
REQ-019 In IDLE, when addr_ld=1 and exc_req=0, SHALL load addr_out <= src_data[sel_src] on the next edge (1-cycle latency); otherwise addr_out holds.
REQ-020 In IDLE, when exc_req=1, SHALL load addr_out <= VEC_BASE + min(exc_code, NUM_VEC-1), zero-extended to DATA_W, set busy and enter WAIT; exc_req SHALL win over a simultaneous addr_ld.
REQ-021 In WAIT, SHALL count MEM_LAT cycles with a 3-bit counter, then capture {zeros, mem_rdata} into vec_addr and enter DONE.
REQ-022 In DONE, SHALL assert vec_valid for exactly one cycle, clear busy and return to IDLE.
REQ-023 While busy, SHALL ignore addr_ld and keep addr_out stable.
REQ-024 vec_addr SHALL hold its value until the next capture.

Reset
REQ-025 On reset=1 at a clock edge, SHALL set state=IDLE, addr_out=0, vec_addr=0, busy=0, vec_valid=0, counter=0 and pending=0, aborting any fetch in progress.

Configuration
REQ-026 SHALL provide macro MEM_ADDR_SEQ_PEND_EN.
- Defined: exc_req arriving while busy or in DONE SHALL be stored in a 1-deep pending register together with its exc_code. It SHALL be started from IDLE on the cycle after DONE, ahead of addr_ld. A further request while pending is already full SHALL be dropped.
- Undefined: exc_req while busy or in DONE SHALL be ignored, and no pending register SHALL exist.

Structure
REQ-027 Package cpu_pkg SHALL hold the FSM state enum and the default vector-base constant.
REQ-028 The general source selection SHALL be a sub-module src_mux, a parametric NUM_SRC-to-1 mux of DATA_W-bit inputs, and SHALL be combinational.

Verification
REQ-029 With src_data={32'hA0, 32'h40}, sel_src=1 and addr_ld=1 for one cycle, addr_out SHALL be 32'hA0 on the next cycle.
REQ-030 With MEM_LAT=1, exc_code=2 and mem_rdata=8'h7C, addr_out SHALL be 255 with busy=1, and vec_addr SHALL be 32'h7C with a one-cycle vec_valid pulse.
REQ-031 With exc_code=3 (above NUM_VEC-1), addr_out SHALL be 255.
REQ-032 With exc_req and addr_ld asserted in the same cycle, addr_out SHALL be the vector address, not the source.
REQ-033 With reset asserted during WAIT, all outputs SHALL be 0 on the next cycle and vec_valid SHALL never pulse.
REQ-034 With the macro defined, a second exc_req (code 0) during WAIT SHALL produce addr_out=253 on the cycle after the first fetch's DONE; with the macro undefined, it SHALL have no effect.
